// File: rtl/sdio_card_cmd_rsp.sv
// sdio_card_cmd_rsp
//   Card-side SD CMD line responder. Deserialises 48-bit host commands
//   (CRC7 and end bit checked), presents op/arg to the card model, then
//   serialises a 48-bit (R1/R3/R6/R7) or 136-bit (R2) response.
// Ports
//   clk_i, rst_i        SD card clock, synchronous active-high reset
//   clr_stat_i          clears sticky status_o bits
//   sdcmd_i             CMD line input
//   sdcmd_o/oen_o       CMD line output value / enable (active-low)
//   cmd_valid_o         one-cycle pulse per received command
//   cmd_op_o/arg_o      command index / argument, held until next command
//   cmd_crc_err_o       qualifies cmd_valid_o: CRC7 or end-bit error
//   rsp_valid_i/ready_o response handshake (ready only while waiting)
//   rsp_type_i          0 none, 1 48-bit, 2 136-bit, 3 treated as none
//   rsp_data_i          48-bit: [37:0]={idx,arg}; 136-bit: [127:8] payload
//   busy_o              any state other than IDLE
//   status_o            sticky {overrun, timeout, end_err, crc_err}
module sdio_card_cmd_rsp #(
   parameter int NCR         = 2,
   parameter int RSP_TIMEOUT = 64
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_stat_i,
   input  logic         sdcmd_i,
   output logic         sdcmd_o,
   output logic         sdcmd_oen_o,
   output logic         cmd_valid_o,
   output logic [5:0]   cmd_op_o,
   output logic [31:0]  cmd_arg_o,
   output logic         cmd_crc_err_o,
   input  logic         rsp_valid_i,
   output logic         rsp_ready_o,
   input  logic [1:0]   rsp_type_i,
   input  logic [127:0] rsp_data_i,
   output logic         busy_o,
   output logic [3:0]   status_o
);

   localparam int CW = $clog2(RSP_TIMEOUT + 1) + 1;

   typedef enum logic [1:0] {S_IDLE, S_RX, S_WAIT, S_TX} state_t;

   state_t         r_state;
   logic [7:0]     r_cnt;     // RX: index of bit being sampled; TX: index of bit on the line
   logic [6:0]     r_crc;
   logic [46:0]    r_sh;      // received bits 0..46, bit 0 ends up at [46]
   logic [135:0]   r_tx;      // outgoing bits, next data bit at [135]
   logic           r_long;
   logic           r_pend;    // response accepted, waiting for NCR to elapse
   logic [CW-1:0]  r_wcnt;    // cycles since the command end bit
   logic [3:0]     r_status;

   function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
      logic fb;
      fb = b ^ c[6];
      return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
   endfunction

   logic         w_hs, w_ncr_ok, w_rx_crc_bad, w_unused;
   logic [7:0]   w_nxt, w_lo, w_hi;
   logic [6:0]   w_crc_cur;
   logic [135:0] w_txld;

   assign w_hs         = rsp_valid_i & rsp_ready_o;
   assign w_ncr_ok     = (r_wcnt >= CW'(NCR - 1));
   assign w_rx_crc_bad = (r_sh[6:0] != r_crc);
   assign w_nxt        = r_cnt + 8'd1;
   // CRC coverage: whole 40-bit header for short frames, payload only for R2
   assign w_lo         = r_long ? 8'd8   : 8'd0;
   assign w_hi         = r_long ? 8'd127 : 8'd39;
   assign w_crc_cur    = (r_cnt >= w_lo && r_cnt <= w_hi) ? crc7_step(r_crc, sdcmd_o) : r_crc;
   // frame minus the start bit (driven directly), left-aligned
   assign w_txld       = (rsp_type_i == 2'd2) ? {1'b0, 6'h3F, rsp_data_i[127:8], 9'b0}
                                              : {1'b0, rsp_data_i[37:0], 97'b0};
   assign w_unused     = ^{rsp_data_i[7:0], r_sh[46:45]};

   assign rsp_ready_o  = (r_state == S_WAIT) && !r_pend;
   assign busy_o       = (r_state != S_IDLE);
   assign status_o     = r_status;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_crc         <= '0;
         r_sh          <= '0;
         r_tx          <= '0;
         r_long        <= 1'b0;
         r_pend        <= 1'b0;
         r_wcnt        <= '0;
         r_status      <= '0;
         sdcmd_o       <= 1'b1;
         sdcmd_oen_o   <= 1'b1;
         cmd_valid_o   <= 1'b0;
         cmd_op_o      <= '0;
         cmd_arg_o     <= '0;
         cmd_crc_err_o <= 1'b0;
      end else begin
         cmd_valid_o <= 1'b0;
         // later bit writes below override this, so a same-cycle error sticks
         if (clr_stat_i) r_status <= '0;
         case (r_state)
            S_IDLE: begin
               if (!sdcmd_i) begin
                  r_state <= S_RX;
                  r_cnt   <= 8'd1;
                  r_crc   <= '0;
                  r_sh    <= '0;
               end
            end
            S_RX: begin
               r_sh  <= {r_sh[45:0], sdcmd_i};
               r_cnt <= w_nxt;
               if (r_cnt <= 8'd39) r_crc <= crc7_step(r_crc, sdcmd_i);
               if (r_cnt == 8'd1 && !sdcmd_i) begin
                  r_state <= S_IDLE;           // not a host frame
               end else if (r_cnt == 8'd47) begin
                  cmd_valid_o   <= 1'b1;
                  cmd_op_o      <= r_sh[44:39];
                  cmd_arg_o     <= r_sh[38:7];
                  cmd_crc_err_o <= w_rx_crc_bad | ~sdcmd_i;
                  if (w_rx_crc_bad) r_status[0] <= 1'b1;
                  if (!sdcmd_i)     r_status[1] <= 1'b1;
                  if (w_rx_crc_bad || !sdcmd_i) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_state <= S_WAIT;
                     r_wcnt  <= CW'(1);
                     r_pend  <= 1'b0;
                  end
               end
            end
            S_WAIT: begin
               if (!sdcmd_i) begin
                  // host started a new command: drop whatever was pending
                  r_status[3] <= 1'b1;
                  r_pend      <= 1'b0;
                  r_state     <= S_RX;
                  r_cnt       <= 8'd1;
                  r_crc       <= '0;
                  r_sh        <= '0;
               end else begin
                  r_wcnt <= r_wcnt + CW'(1);
                  if (w_hs) begin
                     r_tx   <= w_txld;
                     r_long <= (rsp_type_i == 2'd2);
                     if (rsp_type_i == 2'd0 || rsp_type_i == 2'd3) begin
                        r_state <= S_IDLE;
                     end else if (w_ncr_ok) begin
                        r_state     <= S_TX;
                        sdcmd_o     <= 1'b0;
                        sdcmd_oen_o <= 1'b0;
                        r_cnt       <= '0;
                        r_crc       <= '0;
                     end else begin
                        r_pend <= 1'b1;
                     end
                  end else if (r_pend && w_ncr_ok) begin
                     r_pend      <= 1'b0;
                     r_state     <= S_TX;
                     sdcmd_o     <= 1'b0;
                     sdcmd_oen_o <= 1'b0;
                     r_cnt       <= '0;
                     r_crc       <= '0;
                  end else if (!r_pend && r_wcnt == CW'(RSP_TIMEOUT)) begin
                     r_status[2] <= 1'b1;
                     r_state     <= S_IDLE;
                  end
               end
            end
            S_TX: begin
               // w_crc_cur already includes the bit currently on the line
               r_cnt <= w_nxt;
               if (w_nxt <= w_hi) begin
                  sdcmd_o <= r_tx[135];
                  r_tx    <= {r_tx[134:0], 1'b0};
                  r_crc   <= w_crc_cur;
               end else if (w_nxt <= w_hi + 8'd7) begin
                  sdcmd_o <= w_crc_cur[6];
                  r_crc   <= {w_crc_cur[5:0], 1'b0};
               end else if (w_nxt == w_hi + 8'd8) begin
                  sdcmd_o <= 1'b1;             // end bit
               end else begin
                  sdcmd_o     <= 1'b1;
                  sdcmd_oen_o <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sdio_card_cmd_rsp.sv
// Directed bench for sdio_card_cmd_rsp: command decode, R1/R2 responses,
// CRC/end-bit errors, timeout, overrun, mid-response reset.
module tb_sdio_card_cmd_rsp;

   logic         clk = 1'b0;
   logic         rst, clr_stat, sdcmd_i, sdcmd_o, sdcmd_oen;
   logic         cmd_valid, cmd_crc_err, rsp_valid, rsp_ready, busy;
   logic [5:0]   cmd_op;
   logic [31:0]  cmd_arg;
   logic [1:0]   rsp_type;
   logic [127:0] rsp_data;
   logic [3:0]   status;

   int n_tests = 0;
   int n_fail  = 0;
   int n_valid = 0;

   always #5 clk = ~clk;
   always @(posedge clk) if (cmd_valid) n_valid++;

   sdio_card_cmd_rsp #(.NCR(2), .RSP_TIMEOUT(64)) dut (
      .clk_i(clk), .rst_i(rst), .clr_stat_i(clr_stat), .sdcmd_i(sdcmd_i),
      .sdcmd_o(sdcmd_o), .sdcmd_oen_o(sdcmd_oen), .cmd_valid_o(cmd_valid),
      .cmd_op_o(cmd_op), .cmd_arg_o(cmd_arg), .cmd_crc_err_o(cmd_crc_err),
      .rsp_valid_i(rsp_valid), .rsp_ready_o(rsp_ready), .rsp_type_i(rsp_type),
      .rsp_data_i(rsp_data), .busy_o(busy), .status_o(status)
   );

   task automatic chk(input string tag, input logic [135:0] got, input logic [135:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // reference CRC7 over the n LSBs of v, MSB first
   function automatic logic [6:0] crc7_of(input logic [135:0] v, input int n);
      logic [6:0] c;
      logic       fb;
      c = '0;
      for (int i = n - 1; i >= 0; i--) begin
         fb = v[i] ^ c[6];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction

   function automatic logic [47:0] mk_frame(input logic [5:0] op, input logic [31:0] arg);
      logic [39:0] h;
      h = {2'b01, op, arg};
      return {h, crc7_of({96'b0, h}, 40), 1'b1};
   endfunction

   // drives one host frame; returns just after the edge that sampled the end bit
   task automatic send_frame(input logic [47:0] f);
      for (int i = 47; i >= 0; i--) begin
         @(negedge clk);
         sdcmd_i = f[i];
      end
      @(negedge clk);
      sdcmd_i = 1'b1;
   endtask

   // called with the start bit on the line; collects bits while oen is low
   task automatic get_rsp(output logic [135:0] bits, output int n);
      bits = '0;
      n    = 0;
      while (sdcmd_oen == 1'b0 && n < 200) begin
         bits = {bits[134:0], sdcmd_o};
         n++;
         @(negedge clk);
      end
   endtask

   task automatic reply(input logic [1:0] t, input logic [127:0] d);
      rsp_valid = 1'b1;
      rsp_type  = t;
      rsp_data  = d;
      @(negedge clk);
      rsp_valid = 1'b0;
   endtask

   task automatic clear_status();
      @(negedge clk);
      clr_stat = 1'b1;
      @(negedge clk);
      clr_stat = 1'b0;
   endtask

   logic [135:0] bits, exp136;
   logic [47:0]  f, exp48;
   logic [39:0]  hdr;
   logic [119:0] pay;
   logic [6:0]   c17;
   logic         drove;
   int           n, v0;

   initial begin
      rst = 1'b1; clr_stat = 1'b0; sdcmd_i = 1'b1;
      rsp_valid = 1'b0; rsp_type = 2'd0; rsp_data = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_oen", sdcmd_oen, 1);
      chk("rst_cmd", sdcmd_o, 1);
      chk("rst_busy", busy, 0);
      chk("rst_ready", rsp_ready, 0);
      chk("rst_status", status, 0);
      chk("rst_op_arg", {cmd_op, cmd_arg, cmd_valid, cmd_crc_err}, 0);

      // CMD0, no response: line never driven
      send_frame(48'h40_0000_0000_95);
      chk("cmd0_valid", cmd_valid, 1);
      chk("cmd0_op", cmd_op, 0);
      chk("cmd0_arg", cmd_arg, 0);
      chk("cmd0_crcerr", cmd_crc_err, 0);
      chk("cmd0_ready", rsp_ready, 1);
      drove = 1'b0;
      rsp_valid = 1'b1; rsp_type = 2'd0;
      @(negedge clk);
      rsp_valid = 1'b0;
      repeat (4) begin
         if (!sdcmd_oen) drove = 1'b1;
         @(negedge clk);
      end
      chk("cmd0_nodrive", drove, 0);
      chk("cmd0_idle", busy, 0);

      // CMD8 with R7 response, start bit NCR=2 after end bit
      send_frame(48'h48_0000_01AA_87);
      chk("cmd8_op", cmd_op, 8);
      chk("cmd8_arg", cmd_arg, 32'h1AA);
      chk("cmd8_early", sdcmd_oen, 1);
      reply(2'd1, 128'h08_0000_01AA);
      chk("r7_start_oen", sdcmd_oen, 0);
      chk("r7_start_bit", sdcmd_o, 0);
      get_rsp(bits, n);
      hdr   = {2'b00, 6'h08, 32'h0000_01AA};
      exp48 = {hdr, crc7_of({96'b0, hdr}, 40), 1'b1};
      chk("r7_len", n, 48);
      chk("r7_bits", bits, {88'b0, exp48});
      chk("r7_idle", {busy, sdcmd_o}, 2'b01);

      // CMD17 from the vector table: crc field 0x2A, end bit 0
      c17 = crc7_of({96'b0, 40'h51_0000_0000}, 40);
      send_frame(48'h51_0000_0000_54);
      chk("cmd17_valid", cmd_valid, 1);
      chk("cmd17_err", cmd_crc_err, 1);
      chk("cmd17_status", status, {2'b00, 1'b1, (c17 != 7'h2A)});
      @(negedge clk);
      chk("cmd17_norsp", {busy, sdcmd_oen}, 2'b01);
      clear_status();
      chk("clr_status", status, 0);

      // pure CRC error, with clear held through the erroring edge
      f = mk_frame(6'd17, 32'h0) ^ 48'h2;
      clr_stat = 1'b1;
      send_frame(f);
      chk("crc_err_flag", cmd_crc_err, 1);
      chk("crc_beats_clr", status, 4'b0001);
      clr_stat = 1'b0;
      clear_status();

      // CMD2 with R2 response
      send_frame(mk_frame(6'd2, 32'h0));
      chk("cmd2_op", {cmd_crc_err, cmd_op}, 7'd2);
      reply(2'd2, {{15{8'hA5}}, 8'h00});
      chk("r2_start", {sdcmd_oen, sdcmd_o}, 2'b00);
      get_rsp(bits, n);
      pay    = {15{8'hA5}};
      exp136 = {2'b00, 6'h3F, pay, crc7_of({16'b0, pay}, 120), 1'b1};
      chk("r2_len", n, 136);
      chk("r2_bits", bits, exp136);
      chk("r2_idle", busy, 0);

      // timeout: abandoned exactly at the 64th waiting cycle
      send_frame(48'h48_0000_01AA_87);
      repeat (63) @(negedge clk);
      chk("to_still_wait", {busy, rsp_ready}, 2'b11);
      @(negedge clk);
      chk("to_idle", busy, 0);
      chk("to_status", status, 4'b0100);
      clear_status();

      // overrun: new command while waiting for a response
      send_frame(48'h48_0000_01AA_87);
      send_frame(48'h40_0000_0000_95);
      chk("ovr_valid", cmd_valid, 1);
      chk("ovr_op", cmd_op, 0);
      chk("ovr_status", status, 4'b1000);
      reply(2'd0, '0);
      chk("ovr_idle", busy, 0);

      // reset in the middle of a response
      send_frame(48'h48_0000_01AA_87);
      reply(2'd1, 128'h08_0000_01AA);
      repeat (20) @(negedge clk);
      chk("pre_rst_drive", sdcmd_oen, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_oen", {sdcmd_oen, sdcmd_o}, 2'b11);
      chk("mid_rst_regs", {busy, status, cmd_op, cmd_arg}, 0);
      send_frame(48'h40_0000_0000_95);
      chk("post_rst_cmd0", {cmd_valid, cmd_crc_err, cmd_op}, {1'b1, 7'd0});
      reply(2'd0, '0);

      // transmission bit 0: silently dropped
      v0 = n_valid;
      @(negedge clk); sdcmd_i = 1'b0;
      @(negedge clk); sdcmd_i = 1'b0;
      @(negedge clk); sdcmd_i = 1'b1;
      repeat (3) @(negedge clk);
      chk("tbit_idle", busy, 0);
      chk("tbit_nopulse", n_valid, v0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

endmodule
